// File: rtl/axis_fifo_wr_bridge.sv
// rtl/axis_fifo_wr_bridge.sv - AXI-Stream slave to async FIFO write-port bridge with skid buffer
// Packs {tlast,tdata} into FIFO words; tready is decoded from flops only, never from wr_full.
module axis_fifo_wr_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  wr_reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH:0]   fifo_wr_data_o,
    output logic                  fifo_wr_en_o,
    input  logic                  fifo_wr_full_i,
    output logic [CNT_WIDTH-1:0]  pkt_count_o,
    output logic [CNT_WIDTH-1:0]  beat_count_o,
    output logic                  in_pkt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    occ_e                  state_q, state_d;
    logic [DATA_WIDTH:0]   main_q, main_d;
    logic [DATA_WIDTH:0]   skid_q, skid_d;
    logic                  ready_en_q;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;
    logic                  in_pkt_q, in_pkt_d;

    logic                  accept;
    logic                  write;
    logic [DATA_WIDTH:0]   in_word;

    assign in_word        = {s_axis_tlast, s_axis_tdata};
    assign s_axis_tready  = ready_en_q & (state_q != ST_TWO);
    assign accept         = s_axis_tvalid & s_axis_tready;
    // Gating by full here is what keeps the FIFO from ever seeing an enable while full.
    assign write          = (state_q != ST_EMPTY) & ~fifo_wr_full_i;
    assign fifo_wr_en_o   = write;
    assign fifo_wr_data_o = main_q;
    assign pkt_count_o    = pkt_q;
    assign beat_count_o   = beat_q;
    assign in_pkt_o       = in_pkt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_word;
                end
            end
            ST_ONE: begin
                if (accept && write) begin
                    main_d = in_word;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_word;
                end else if (write) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (write) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        pkt_d    = pkt_q;
        beat_d   = beat_q;
        in_pkt_d = in_pkt_q;
        if (write) begin
            if (main_q[DATA_WIDTH]) begin
                pkt_d    = pkt_q + CNT_ONE;
                beat_d   = '0;
                in_pkt_d = 1'b0;
            end else begin
                beat_d   = beat_q + CNT_ONE;
                in_pkt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            ready_en_q <= 1'b0;
            pkt_q      <= '0;
            beat_q     <= '0;
            in_pkt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            ready_en_q <= 1'b1;
            pkt_q      <= pkt_d;
            beat_q     <= beat_d;
            in_pkt_q   <= in_pkt_d;
        end
    end

endmodule

// File: tb/tb_axis_fifo_wr_bridge.sv
// tb/tb_axis_fifo_wr_bridge.sv - testbench for axis_fifo_wr_bridge
// Scenario tasks run in sequence; a negedge scoreboard tracks accepted beats and FIFO writes.
module tb_axis_fifo_wr_bridge;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          wr_clk = 1'b0;
    logic          wr_reset_n = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW:0]   fifo_wr_data_o;
    logic          fifo_wr_en_o;
    logic          fifo_wr_full_i = 1'b0;
    logic [CW-1:0] pkt_count_o;
    logic [CW-1:0] beat_count_o;
    logic          in_pkt_o;

    axis_fifo_wr_bridge #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .wr_clk         (wr_clk),
        .wr_reset_n     (wr_reset_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_full_i (fifo_wr_full_i),
        .pkt_count_o    (pkt_count_o),
        .beat_count_o   (beat_count_o),
        .in_pkt_o       (in_pkt_o)
    );

    always #5 wr_clk = ~wr_clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_wr = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] wr_log[$];
    int          wr_cyc[$];
    logic [CW-1:0] m_pkt = '0;
    logic [CW-1:0] m_beat = '0;
    logic          m_inpkt = 1'b0;
    bit            saw_inpkt = 0;
    bit            saw_beat_nz = 0;

    always @(posedge wr_clk) cyc++;

    // Reference model: a queue of accepted words plus packet/beat counting rules.
    always @(negedge wr_clk) begin
        logic [DW:0] w;
        if (!wr_reset_n) begin
            exp_q.delete();
            m_pkt = '0;
            m_beat = '0;
            m_inpkt = 1'b0;
        end else begin
            n_total++;
            if ({pkt_count_o, beat_count_o, in_pkt_o} !== {m_pkt, m_beat, m_inpkt})
                $display("FAIL counters: got pkt=%0d beat=%0d in_pkt=%0b, want pkt=%0d beat=%0d in_pkt=%0b",
                         pkt_count_o, beat_count_o, in_pkt_o, m_pkt, m_beat, m_inpkt);
            else n_pass++;
            n_total++;
            if ((fifo_wr_en_o & fifo_wr_full_i) !== 1'b0)
                $display("FAIL en_while_full: en=%b full=%b, want en=0", fifo_wr_en_o, fifo_wr_full_i);
            else n_pass++;
            if (in_pkt_o) saw_inpkt = 1;
            if (beat_count_o != 0) saw_beat_nz = 1;
            if (fifo_wr_en_o === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_write: got data=%h, want no write", fifo_wr_data_o);
                end else begin
                    w = exp_q.pop_front();
                    if (fifo_wr_data_o !== w)
                        $display("FAIL write_data: got %h, want %h", fifo_wr_data_o, w);
                    else n_pass++;
                    if (w[DW]) begin
                        m_pkt = m_pkt + 1'b1;
                        m_beat = '0;
                        m_inpkt = 1'b0;
                    end else begin
                        m_beat = m_beat + 1'b1;
                        m_inpkt = 1'b1;
                    end
                end
                wr_log.push_back(fifo_wr_data_o);
                wr_cyc.push_back(cyc);
                n_wr++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back({s_axis_tlast, s_axis_tdata});
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int t;
        t = 0;
        s_axis_tdata = d;
        s_axis_tlast = l;
        s_axis_tvalid = 1'b1;
        @(negedge wr_clk);
        while (!s_axis_tready && t < 200) begin
            @(negedge wr_clk);
            t++;
        end
        if (t >= 200) begin
            n_total++;
            $display("FAIL send_timeout: tready=%b after %0d cycles, want 1", s_axis_tready, t);
        end
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge wr_clk);
            t++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d beats left, want 0", exp_q.size());
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        fifo_wr_full_i = 1'b0;
        wr_reset_n = 1'b0;
        repeat (2) tick();
        wr_reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        bit en_seen;
        wr_reset_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({s_axis_tready, fifo_wr_en_o, fifo_wr_data_o, pkt_count_o, beat_count_o, in_pkt_o} !== '0)
            $display("FAIL reset_outputs: got tready=%b en=%b data=%h pkt=%0d beat=%0d in_pkt=%b, want all 0",
                     s_axis_tready, fifo_wr_en_o, fifo_wr_data_o, pkt_count_o, beat_count_o, in_pkt_o);
        else n_pass++;
        wr_reset_n = 1'b1;
        @(negedge wr_clk);
        n_total++;
        if (s_axis_tready !== 1'b0) $display("FAIL tready_before_edge: got %b, want 0", s_axis_tready);
        else n_pass++;
        tick();
        n_total++;
        if (s_axis_tready !== 1'b1) $display("FAIL tready_after_edge: got %b, want 1", s_axis_tready);
        else n_pass++;
        en_seen = 0;
        repeat (5) begin
            @(negedge wr_clk);
            if (fifo_wr_en_o !== 1'b0) en_seen = 1;
        end
        n_total++;
        if (en_seen) $display("FAIL idle_en: got en=1 while idle, want 0");
        else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        logic [DW:0] e;
        wr_log.delete();
        wr_cyc.delete();
        for (int i = 1; i <= 8; i++) send(DW'(i), (i == 8));
        drain();
        n_total++;
        if (wr_log.size() != 8) $display("FAIL stream_count: got %0d writes, want 8", wr_log.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            e = {(i == 7) ? 1'b1 : 1'b0, DW'(i + 1)};
            n_total++;
            if (wr_log[i] !== e) $display("FAIL stream_data[%0d]: got %h, want %h", i, wr_log[i], e);
            else n_pass++;
            n_total++;
            if (wr_cyc[i] != wr_cyc[0] + i)
                $display("FAIL stream_cycle[%0d]: got cycle %0d, want %0d", i, wr_cyc[i], wr_cyc[0] + i);
            else n_pass++;
        end
        n_total++;
        if (pkt_count_o !== 16'd1 || beat_count_o !== 16'd0)
            $display("FAIL stream_counters: got pkt=%0d beat=%0d, want pkt=1 beat=0", pkt_count_o, beat_count_o);
        else n_pass++;
    endtask

    task automatic test_full_burst();
        int a0;
        logic [DW:0] e [4];
        e[0] = 9'h0A0; e[1] = 9'h0A1; e[2] = 9'h0A2; e[3] = 9'h1A3;
        wr_log.delete();
        a0 = n_acc;
        fifo_wr_full_i = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 8'hA0;
        tick();
        s_axis_tdata = 8'hA1;
        tick();
        s_axis_tdata = 8'hA2;
        repeat (3) tick();
        @(negedge wr_clk);
        n_total++;
        if (s_axis_tready !== 1'b0 || fifo_wr_en_o !== 1'b0)
            $display("FAIL full_hold: got tready=%b en=%b, want 0 0", s_axis_tready, fifo_wr_en_o);
        else n_pass++;
        n_total++;
        if (n_acc - a0 != 2 || wr_log.size() != 0)
            $display("FAIL full_accepts: got %0d accepts %0d writes, want 2 0", n_acc - a0, wr_log.size());
        else n_pass++;
        fifo_wr_full_i = 1'b0;
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        drain();
        n_total++;
        if (wr_log.size() != 4) $display("FAIL full_count: got %0d writes, want 4", wr_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            n_total++;
            if (wr_log[i] !== e[i]) $display("FAIL full_data[%0d]: got %h, want %h", i, wr_log[i], e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int sent, t, a0, w0;
        sent = 0; t = 0; a0 = n_acc; w0 = n_wr;
        while (sent < 1000 && t < 20000) begin
            s_axis_tvalid = ($urandom_range(3) != 0);
            s_axis_tdata = DW'($urandom);
            s_axis_tlast = ($urandom_range(7) == 0);
            fifo_wr_full_i = ($urandom_range(2) == 0);
            @(negedge wr_clk);
            if (s_axis_tvalid && s_axis_tready) sent++;
            tick();
            t++;
        end
        s_axis_tvalid = 1'b0;
        fifo_wr_full_i = 1'b0;
        drain();
        n_total++;
        if (n_acc - a0 != 1000 || n_wr - w0 != 1000)
            $display("FAIL random_totals: got %0d accepts %0d writes, want 1000 1000", n_acc - a0, n_wr - w0);
        else n_pass++;
    endtask

    task automatic test_single_beat_pkts();
        do_reset();
        saw_inpkt = 0;
        saw_beat_nz = 0;
        for (int i = 0; i < 5; i++) send(DW'($urandom), 1'b1);
        drain();
        n_total++;
        if (pkt_count_o !== 16'd5 || beat_count_o !== 16'd0)
            $display("FAIL single_counters: got pkt=%0d beat=%0d, want 5 0", pkt_count_o, beat_count_o);
        else n_pass++;
        n_total++;
        if (saw_inpkt || saw_beat_nz)
            $display("FAIL single_flags: got in_pkt_seen=%0b beat_nz_seen=%0b, want 0 0", saw_inpkt, saw_beat_nz);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [DW:0] e0, e1;
        e0 = 9'h055; e1 = 9'h156;
        do_reset();
        send(8'h11, 1'b0);
        tick();
        fifo_wr_full_i = 1'b1;
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        @(negedge wr_clk);
        n_total++;
        if (s_axis_tready !== 1'b0 || in_pkt_o !== 1'b1 || beat_count_o !== 16'd1)
            $display("FAIL two_state: got tready=%b in_pkt=%b beat=%0d, want 0 1 1", s_axis_tready, in_pkt_o, beat_count_o);
        else n_pass++;
        @(posedge wr_clk);
        #2;
        fifo_wr_full_i = 1'b0;
        wr_reset_n = 1'b0;
        #1;
        n_total++;
        if ({s_axis_tready, fifo_wr_en_o, fifo_wr_data_o, pkt_count_o, beat_count_o, in_pkt_o} !== '0)
            $display("FAIL async_reset: got tready=%b en=%b data=%h pkt=%0d beat=%0d in_pkt=%b, want all 0",
                     s_axis_tready, fifo_wr_en_o, fifo_wr_data_o, pkt_count_o, beat_count_o, in_pkt_o);
        else n_pass++;
        repeat (2) tick();
        wr_reset_n = 1'b1;
        wr_log.delete();
        send(8'h55, 1'b0);
        send(8'h56, 1'b1);
        drain();
        n_total++;
        if (wr_log.size() != 2 || wr_log[0] !== e0 || wr_log[1] !== e1)
            $display("FAIL restart_data: got %0d writes, want 2 (055,156)", wr_log.size());
        else n_pass++;
        n_total++;
        if (pkt_count_o !== 16'd1) $display("FAIL restart_pkt: got %0d, want 1", pkt_count_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_burst();
        test_random();
        test_single_beat_pkts();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
